// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 load/store codes, write-back
// select, FSM states and the access-legality helper.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } memState_e;

  // Exactly one of load/store, a defined funct3 for that direction, and natural alignment.
  function automatic logic legalAccess(input logic isLoad, input logic isStore,
                                       input logic [2:0] f3, input logic [1:0] addrLo);
    logic ok;
    ok = 1'b0;
    if (isLoad && !isStore) begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~addrLo[0];
        F3_LW:         ok = (addrLo == 2'b00);
        default:       ok = 1'b0;
      endcase
    end else if (isStore && !isLoad) begin
      case (f3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~addrLo[0];
        F3_SW:   ok = (addrLo == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface memory_cycle_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane
// selection with sign/zero extension. Purely combinational.
module load_store_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            isStore,
  input  logic [1:0]      addrLo,
  input  logic [XLEN-1:0] storeData,
  input  logic [XLEN-1:0] loadWord,
  output logic [3:0]      byteEn,
  output logic [XLEN-1:0] storeLanes,
  output logic [XLEN-1:0] loadData
);

  logic [XLEN-1:0] laneWord;

  always_comb begin
    laneWord   = loadWord >> {addrLo, 3'b000};
    byteEn     = '1;
    storeLanes = storeData;
    loadData   = loadWord;
    // Store and load codes coincide for B/H/W, so one case covers both directions.
    case (funct3)
      F3_LB: begin
        storeLanes = {(XLEN/8){storeData[7:0]}};
        loadData   = {{(XLEN-8){laneWord[7]}}, laneWord[7:0]};
        if (isStore) byteEn = 4'b0001 << addrLo;
      end
      F3_LH: begin
        storeLanes = {(XLEN/16){storeData[15:0]}};
        loadData   = {{(XLEN-16){laneWord[15]}}, laneWord[15:0]};
        if (isStore) byteEn = 4'b0011 << addrLo;
      end
      F3_LBU: loadData = {{(XLEN-8){1'b0}}, laneWord[7:0]};
      F3_LHU: loadData = {{(XLEN-16){1'b0}}, laneWord[15:0]};
      default: begin
        storeLanes = storeData;
        loadData   = loadWord;
      end
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM pipeline stage: issues data-memory accesses, waits for ready with a
// bounded timeout, and registers results into the MEM/WB stage.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic [1:0]      Mem_to_RegM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  memory_cycle_if.master  dmem,
  output logic            RegWriteW,
  output logic [1:0]      Mem_to_RegW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] ALUOutW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic            StallM,
  output logic            ExcM,
  output logic            BusErrM
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  memState_e       state, stateNext;
  logic [CW-1:0]   waitCnt;
  logic            memOp, legalOp, excNow, timeout, bubble;
  logic [3:0]      byteEn;
  logic [XLEN-1:0] storeLanes, loadData;

  load_store_align #(.XLEN(XLEN)) align (
    .funct3    (funct3M),
    .isStore   (MemWriteM),
    .addrLo    (ALUOutM[1:0]),
    .storeData (WriteDataM),
    .loadWord  (dmem.dmem_rdata),
    .byteEn    (byteEn),
    .storeLanes(storeLanes),
    .loadData  (loadData)
  );

  // The issue cycle in IDLE counts as the first unanswered cycle, so WAIT gives
  // up while the counter reads TIMEOUT-1; it reaches TIMEOUT on that same edge.
  always_comb begin
    memOp     = MemReadM | MemWriteM;
    legalOp   = legalAccess(MemReadM, MemWriteM, funct3M, ALUOutM[1:0]);
    excNow    = memOp & ~legalOp;
    timeout   = (state == WAIT) && (waitCnt == CNT_LAST) && !dmem.dmem_ready;
    StallM    = legalOp & ~dmem.dmem_ready & ~timeout;
    bubble    = StallM | excNow | timeout;
    stateNext = state;
    case (state)
      IDLE:    if (legalOp && !dmem.dmem_ready) stateNext = WAIT;
      WAIT:    if (dmem.dmem_ready || timeout) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign dmem.dmem_req   = legalOp & ~timeout & ~rst;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = {ALUOutM[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata = storeLanes;
  assign dmem.dmem_be    = byteEn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (state == IDLE && stateNext == WAIT) begin
      waitCnt <= '0;
    end else if (state == WAIT && waitCnt != CNT_MAX) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      Mem_to_RegW <= MTR_ALU;
      RD_W        <= '0;
      ALUOutW     <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      ExcM        <= 1'b0;
      BusErrM     <= 1'b0;
    end else begin
      ExcM    <= excNow;
      BusErrM <= timeout;
      if (bubble) begin
        RegWriteW   <= 1'b0;
        Mem_to_RegW <= MTR_ALU;
        RD_W        <= '0;
        ALUOutW     <= '0;
        ReadDataW   <= '0;
        PCPlus4W    <= '0;
      end else begin
        RegWriteW   <= RegWriteM;
        Mem_to_RegW <= Mem_to_RegM;
        RD_W        <= RD_M;
        ALUOutW     <= ALUOutM;
        ReadDataW   <= (legalOp && MemReadM) ? loadData : '0;
        PCPlus4W    <= PCPlus4M;
      end
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: vector table for single-cycle accesses plus
// hand-written stall, timeout and reset sequences, checked via a W-stage scoreboard.
module tb_memory_cycle;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  Mem_to_RegM;
  logic [2:0]  funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALUOutM, WriteDataM, PCPlus4M;
  logic        RegWriteW, StallM, ExcM, BusErrM;
  logic [1:0]  Mem_to_RegW;
  logic [4:0]  RD_W;
  logic [31:0] ALUOutW, ReadDataW, PCPlus4W;

  memory_cycle_if #(.XLEN(XLEN)) dmem ();

  memory_cycle #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .Mem_to_RegM(Mem_to_RegM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .RD_M       (RD_M),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .dmem       (dmem),
    .RegWriteW  (RegWriteW),
    .Mem_to_RegW(Mem_to_RegW),
    .RD_W       (RD_W),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .StallM     (StallM),
    .ExcM       (ExcM),
    .BusErrM    (BusErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regW;
    logic [1:0]  mtr;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4;
    logic        exc, busErr;
  } wExp_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [1:0]  mtr;
    logic        regW;
    logic [4:0]  rdIdx;
    logic [31:0] alu, wd, rdata;
    logic        expReq;
    logic [3:0]  expBe;
    logic [31:0] expWd;
    logic        expExc;
    logic [31:0] expRead;
  } vec_t;

  wExp_t sb[$];
  vec_t  vt[18];
  int    nVec = 0;
  int    nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wExp_t bubbleW(input logic exc, input logic busErr);
    wExp_t e;
    e = '{1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, exc, busErr};
    return e;
  endfunction

  function automatic wExp_t retireW(input logic regW, input logic [1:0] mtr, input logic [4:0] rd,
                                    input logic [31:0] alu, input logic [31:0] rdata,
                                    input logic [31:0] pc4);
    wExp_t e;
    e = '{regW, mtr, rd, alu, rdata, pc4, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic setInstr(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [1:0] mtr, input logic regW, input logic [4:0] rdIdx,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; Mem_to_RegM = mtr;
    RegWriteM = regW; RD_M = rdIdx; ALUOutM = alu; WriteDataM = wd; PCPlus4M = pc4;
  endtask

  // Expected W contents go in when the instruction is presented, come out after the edge.
  task automatic step(input string tag, input wExp_t e);
    wExp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({tag, ".RegWriteW"},   RegWriteW,   x.regW);
    check({tag, ".Mem_to_RegW"}, Mem_to_RegW, x.mtr);
    check({tag, ".RD_W"},        RD_W,        x.rd);
    check({tag, ".ALUOutW"},     ALUOutW,     x.alu);
    check({tag, ".ReadDataW"},   ReadDataW,   x.rdata);
    check({tag, ".PCPlus4W"},    PCPlus4W,    x.pc4);
    check({tag, ".ExcM"},        ExcM,        x.exc);
    check({tag, ".BusErrM"},     BusErrM,     x.busErr);
  endtask

  task automatic checkWZero(input string tag);
    check({tag, ".RegWriteW"},   RegWriteW,   0);
    check({tag, ".Mem_to_RegW"}, Mem_to_RegW, 0);
    check({tag, ".RD_W"},        RD_W,        0);
    check({tag, ".ALUOutW"},     ALUOutW,     0);
    check({tag, ".ReadDataW"},   ReadDataW,   0);
    check({tag, ".PCPlus4W"},    PCPlus4W,    0);
    check({tag, ".ExcM"},        ExcM,        0);
    check({tag, ".BusErrM"},     BusErrM,     0);
  endtask

  // A load that never sees ready: TO stall cycles, then one bus-error bubble, then IDLE.
  task automatic runTimeout(input string tag);
    setInstr(1'b1, 1'b0, F3_LW, MTR_MEM, 1'b1, 5'd3, 32'h0000_1008, 32'd0, 32'h0000_0500);
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk);
      check($sformatf("%s.c%0d.stall", tag, k), StallM, (k < TO) ? 1 : 0);
      check($sformatf("%s.c%0d.req", tag, k), dmem.dmem_req, (k < TO) ? 1 : 0);
      step($sformatf("%s.c%0d", tag, k), bubbleW(1'b0, k == TO));
    end
    setInstr(1'b0, 1'b0, 3'b000, MTR_ALU, 1'b1, 5'd4, 32'h0000_0077, 32'd0, 32'h0000_0504);
    @(negedge clk);
    check({tag, ".after.stall"}, StallM, 0);
    step({tag, ".after"}, retireW(1'b1, MTR_ALU, 5'd4, 32'h77, 32'd0, 32'h504));
    setInstr(1'b1, 1'b0, F3_LW, MTR_MEM, 1'b1, 5'd5, 32'h0000_2000, 32'd0, 32'h0000_0508);
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check({tag, ".fresh.stall"}, StallM, 0);
    check({tag, ".fresh.req"}, dmem.dmem_req, 1);
    step({tag, ".fresh"}, retireW(1'b1, MTR_MEM, 5'd5, 32'h2000, 32'h0BAD_F00D, 32'h508));
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, F3_SW,  MTR_ALU, 1'b0, 5'd0,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0,
               1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, F3_SB,  MTR_ALU, 1'b0, 5'd0,  32'h0000_1001, 32'h0000_00A5, 32'h0,
               1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, F3_SH,  MTR_ALU, 1'b0, 5'd0,  32'h0000_1002, 32'h1234_5678, 32'h0,
               1'b1, 4'b1100, 32'h5678_5678, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, F3_SB,  MTR_ALU, 1'b0, 5'd0,  32'h0000_1003, 32'h1122_3344, 32'h0,
               1'b1, 4'b1000, 32'h4444_4444, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, F3_LHU, MTR_MEM, 1'b1, 5'd5,  32'h0000_1002, 32'h0, 32'hBEEF_1234,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_BEEF};
    vt[5]  = '{1'b1, 1'b0, F3_LH,  MTR_MEM, 1'b1, 5'd6,  32'h0000_1002, 32'h0, 32'hBEEF_1234,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFF_BEEF};
    vt[6]  = '{1'b1, 1'b0, F3_LBU, MTR_MEM, 1'b1, 5'd7,  32'h0000_1003, 32'h0, 32'h80FF_0000,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_0080};
    vt[7]  = '{1'b1, 1'b0, F3_LW,  MTR_MEM, 1'b1, 5'd8,  32'h0000_1004, 32'h0, 32'h1234_5678,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'h1234_5678};
    vt[8]  = '{1'b1, 1'b0, F3_LB,  MTR_MEM, 1'b1, 5'd9,  32'h0000_1001, 32'h0, 32'h0000_7F00,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_007F};
    vt[9]  = '{1'b1, 1'b0, F3_LH,  MTR_MEM, 1'b1, 5'd10, 32'h0000_1000, 32'h0, 32'h0000_8001,
               1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFF_8001};
    vt[10] = '{1'b1, 1'b0, F3_LW,  MTR_MEM, 1'b1, 5'd10, 32'h0000_1002, 32'h0, 32'h1111_1111,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[11] = '{1'b1, 1'b0, F3_LH,  MTR_MEM, 1'b1, 5'd11, 32'h0000_1001, 32'h0, 32'h1111_1111,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[12] = '{1'b0, 1'b1, F3_SH,  MTR_ALU, 1'b0, 5'd0,  32'h0000_1003, 32'hAAAA_5555, 32'h0,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[13] = '{1'b1, 1'b0, 3'b011, MTR_MEM, 1'b1, 5'd12, 32'h0000_1000, 32'h0, 32'h2222_2222,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[14] = '{1'b0, 1'b1, 3'b100, MTR_ALU, 1'b0, 5'd0,  32'h0000_1000, 32'h3333_3333, 32'h0,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[15] = '{1'b1, 1'b1, F3_LW,  MTR_MEM, 1'b1, 5'd13, 32'h0000_1000, 32'h4444_4444, 32'h0,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vt[16] = '{1'b0, 1'b0, 3'b000, MTR_ALU, 1'b1, 5'd12, 32'h0000_0055, 32'h0, 32'hFFFF_FFFF,
               1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};
    vt[17] = '{1'b0, 1'b0, 3'b000, MTR_PC4, 1'b1, 5'd1,  32'h0000_0ABC, 32'h0, 32'hFFFF_FFFF,
               1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};

    // Reset: a legal load held on the inputs must not reach the bus.
    rst = 1'b1;
    setInstr(1'b1, 1'b0, F3_LW, MTR_MEM, 1'b1, 5'd2, 32'h0000_1000, 32'd0, 32'h0000_0004);
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'd0;
    #2;
    checkWZero("reset");
    check("reset.req", dmem.dmem_req, 0);
    setInstr(1'b0, 1'b0, 3'b000, MTR_ALU, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      logic [31:0] pc;
      logic [31:0] alu;
      pc  = 32'h400 + 32'(i) * 4;
      alu = vt[i].alu;
      setInstr(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].mtr, vt[i].regW, vt[i].rdIdx,
               vt[i].alu, vt[i].wd, pc);
      dmem.dmem_ready = 1'b1;
      dmem.dmem_rdata = vt[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d.stall", i), StallM, 0);
      check($sformatf("v%0d.req", i), dmem.dmem_req, vt[i].expReq);
      if (vt[i].expReq) begin
        check($sformatf("v%0d.be", i), dmem.dmem_be, vt[i].expBe);
        check($sformatf("v%0d.addr", i), dmem.dmem_addr, {alu[31:2], 2'b00});
        check($sformatf("v%0d.we", i), dmem.dmem_we, vt[i].wr);
        if (vt[i].wr) check($sformatf("v%0d.wdata", i), dmem.dmem_wdata, vt[i].expWd);
      end
      if (vt[i].expExc)
        step($sformatf("v%0d", i), bubbleW(1'b1, 1'b0));
      else
        step($sformatf("v%0d", i), retireW(vt[i].regW, vt[i].mtr, vt[i].rdIdx, vt[i].alu,
                                            vt[i].expRead, pc));
    end

    // LB that waits three cycles for ready: three bubbles, then one retirement.
    setInstr(1'b1, 1'b0, F3_LB, MTR_MEM, 1'b1, 5'd14, 32'h0000_1003, 32'd0, 32'h0000_0600);
    dmem.dmem_rdata = 32'h80FF_0000;
    for (int k = 0; k < 4; k++) begin
      dmem.dmem_ready = (k == 3);
      @(negedge clk);
      check($sformatf("lb.c%0d.stall", k), StallM, (k < 3) ? 1 : 0);
      check($sformatf("lb.c%0d.req", k), dmem.dmem_req, 1);
      check($sformatf("lb.c%0d.addr", k), dmem.dmem_addr, 32'h0000_1000);
      check($sformatf("lb.c%0d.be", k), dmem.dmem_be, 4'b1111);
      if (k < 3) step($sformatf("lb.c%0d", k), bubbleW(1'b0, 1'b0));
      else       step("lb.done", retireW(1'b1, MTR_MEM, 5'd14, 32'h1003, 32'hFFFF_FF80, 32'h600));
    end

    // Asynchronous reset clears a freshly retired W stage without a clock edge.
    setInstr(1'b0, 1'b0, 3'b000, MTR_PC4, 1'b1, 5'd13, 32'h0000_1234, 32'd0, 32'h0000_0088);
    @(negedge clk);
    step("alu", retireW(1'b1, MTR_PC4, 5'd13, 32'h1234, 32'd0, 32'h88));
    rst = 1'b1;
    #1;
    checkWZero("asyncRst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    runTimeout("to1");

    // Reset during the second WAIT cycle: request drops at once, next access starts from IDLE.
    setInstr(1'b1, 1'b0, F3_LW, MTR_MEM, 1'b1, 5'd3, 32'h0000_1008, 32'd0, 32'h0000_0500);
    dmem.dmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("midRst.c%0d.stall", k), StallM, 1);
      step($sformatf("midRst.c%0d", k), bubbleW(1'b0, 1'b0));
    end
    #2;
    check("midRst.req.before", dmem.dmem_req, 1);
    rst = 1'b1;
    #1;
    check("midRst.req", dmem.dmem_req, 0);
    checkWZero("midRst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    runTimeout("to2");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for dmem_ready before bus error.
REQ-003 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have inputs RegWriteM 1, Mem_to_RegM 2 (00 ALU, 01 memory, 10 PC+4), MemReadM 1, MemWriteM 1, funct3M 3, RD_M 5, ALUOutM XLEN, WriteDataM XLEN, PCPlus4M XLEN, all from EX/MEM register.
REQ-006 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr XLEN (word-aligned), dmem_wdata XLEN, dmem_be 4, plus inputs dmem_rdata XLEN and dmem_ready 1.
REQ-007 SHALL have outputs RegWriteW 1, Mem_to_RegW 2, RD_W 5, ALUOutW XLEN, ReadDataW XLEN, PCPlus4W XLEN, forming the registered MEM/WB stage.
REQ-008 SHALL have outputs StallM 1 (to hazard unit), ExcM 1 (misaligned/illegal access pulse), BusErrM 1 (timeout pulse).

Function
REQ-009 mem_op = MemReadM | MemWriteM; exactly one of MemReadM/MemWriteM SHALL be high for an access; both high treated as illegal.
REQ-010 Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store funct3: 000 SB, 001 SH, 010 SW; others illegal.
REQ-011 Misaligned: halfword with ALUOutM[0]=1, word with ALUOutM[1:0]!=00; misaligned or illegal access SHALL not assert dmem_req, SHALL pulse ExcM for one cycle, and SHALL load a bubble into MEM/WB.
REQ-012 dmem_addr = {ALUOutM[XLEN-1:2],2'b00}; dmem_we = MemWriteM; dmem_req = legal mem_op while not in timeout recovery.
REQ-013 Stores: dmem_be = 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), 1111 (SW); dmem_wdata = byte/halfword of WriteDataM replicated across lanes; loads: dmem_be = 1111.
REQ-014 Loads: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; result registered into ReadDataW.
REQ-015 FSM states IDLE, WAIT: IDLE with legal mem_op and dmem_ready=0 -> WAIT; WAIT with dmem_ready=1 -> IDLE; WAIT with counter = TIMEOUT -> IDLE with BusErrM pulse; otherwise hold.
REQ-016 Completion in IDLE on same-cycle dmem_ready SHALL take zero wait cycles (one-cycle stage latency to W outputs).
REQ-017 StallM = legal mem_op & ~dmem_ready & ~timeout, combinational; upstream holds EX/MEM inputs stable while StallM=1.
REQ-018 dmem_req, dmem_addr, dmem_we, dmem_wdata, dmem_be SHALL remain stable from request until dmem_ready or timeout.
REQ-019 Wait counter SHALL clear on entry to WAIT, increment each WAIT cycle, saturate at TIMEOUT.
REQ-020 MEM/WB SHALL capture M-stage values when StallM=0; when StallM=1 SHALL load a bubble (RegWriteW=0, Mem_to_RegW=00, RD_W=0) so no instruction retires twice.
REQ-021 Timeout completion SHALL load a bubble and SHALL not write the register file.
REQ-022 Non-memory instructions SHALL pass through in one cycle, ReadDataW=0.

Reset
REQ-023 rst high SHALL asynchronously force IDLE, counter 0, all W outputs 0, ExcM=0, BusErrM=0, and dmem_req=0 even mid-WAIT.
REQ-024 After rst release, first access SHALL be issued fresh; no pending transaction survives reset.

Structure
REQ-025 Package riscv_pkg SHALL hold funct3 load/store encodings, Mem_to_Reg select encodings, and FSM state enum.
REQ-026 Lane selection, byte-enable, store replication and load extension SHALL be one combinational sub-module load_store_align.

Verification
REQ-027 SW addr 0x0000_1004 data 0xDEAD_BEEF, ready same cycle -> be=1111, wdata=0xDEADBEEF, StallM=0, no wait.
REQ-028 LB addr 0x0000_1003, rdata 0x80FF_0000, ready after 3 cycles -> StallM high 3 cycles, 3 bubbles, ReadDataW=0xFFFF_FF80, RegWriteW=1 once.
REQ-029 LHU addr 0x0000_1002, rdata 0xBEEF_1234 -> ReadDataW=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-030 LW addr 0x0000_1002 -> ExcM pulse, dmem_req=0, RegWriteW=0.
REQ-031 Load with dmem_ready never asserted, TIMEOUT=4 -> StallM 4 cycles, BusErrM one-cycle pulse, bubble, FSM back to IDLE.
REQ-032 rst asserted during WAIT cycle 2 -> dmem_req=0 and all W outputs 0 immediately, IDLE after release.
